// File: rtl/spi_baud_generator.sv
// SPI baud generator: divides PCLK into sclk and issues one-cycle
// sample/shift strobes ahead of each sclk edge, counts bits per byte.
// Ports: PCLK/PRESET (sync, active-high), spi_mode/spiswai/ss gate the
//   clock, sppr/spr select BaudRateDivisor, cpol/cpha set clock shape;
//   outputs sclk, sample_pulse, shift_pulse, bit_cnt, byte_done, cfg_err.
// Optional: define SPI_BAUD_CFG_ERR_EN to flag {sppr,spr} changes in RUN.
module spi_baud_generator #(
    parameter int DIV_W = 12,
    parameter int BITS  = 8
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [1:0]       spi_mode,
    input  logic             spiswai,
    input  logic [2:0]       sppr,
    input  logic [2:0]       spr,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             ss,
    output logic [DIV_W-1:0] BaudRateDivisor,
    output logic             sclk,
    output logic             sample_pulse,
    output logic             shift_pulse,
    output logic [2:0]       bit_cnt,
    output logic             byte_done,
    output logic             cfg_err
);

    typedef enum logic {S_IDLE, S_RUN} state_t;
    // LEAD: the next sclk edge leaves the idle level.
    typedef enum logic {LEAD, TRAIL} phase_t;

    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] half_q, half_d;
    logic             sclk_q, sclk_d;
    logic [2:0]       bit_q, bit_d;
    logic             sample_q, sample_d;
    logic             shift_q, shift_d;
    logic             done_q, done_d;

    logic [DIV_W-1:0] pre;
    logic [DIV_W-1:0] half;
    logic             run;
    logic             fire;
    logic             lead;

    assign pre             = DIV_W'(sppr) + DIV_W'(1);
    assign BaudRateDivisor = pre << ({1'b0, spr} + 4'd1);
    assign half            = BaudRateDivisor >> 1;

    assign run = !ss && (spi_mode == 2'b00 ||
                         (spi_mode == 2'b01 && !spiswai));

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        half_d   = half_q;
        sclk_d   = sclk_q;
        bit_d    = bit_q;
        done_d   = 1'b0;
        sample_d = 1'b0;
        shift_d  = 1'b0;
        fire     = 1'b0;
        lead     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                sclk_d  = cpol;
                cnt_d   = '0;
                bit_d   = '0;
                phase_d = LEAD;
                if (run) begin
                    state_d = S_RUN;
                    half_d  = half;
                end
            end
            S_RUN: begin
                if (!run) begin
                    state_d = S_IDLE;
                    sclk_d  = cpol;
                    cnt_d   = '0;
                    bit_d   = '0;
                    phase_d = LEAD;
                end else if (cnt_q == half_q - DIV_W'(1)) begin
                    cnt_d   = '0;
                    sclk_d  = ~sclk_q;
                    phase_d = (phase_q == LEAD) ? TRAIL : LEAD;
                    if (phase_q == TRAIL) begin
                        if (bit_q == 3'(BITS - 1)) begin
                            bit_d  = '0;
                            done_d = 1'b1;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobe is registered one cycle ahead of the edge it announces:
        // it is decoded from the counter value of the cycle being entered.
        fire     = (state_d == S_RUN) && (cnt_d == half_d - DIV_W'(1));
        lead     = (phase_d == LEAD);
        sample_d = fire && (lead != cpha);
        shift_d  = fire && (lead == cpha);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= S_IDLE;
            phase_q  <= LEAD;
            cnt_q    <= '0;
            half_q   <= DIV_W'(1);
            sclk_q   <= cpol;
            bit_q    <= '0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            sclk_q   <= sclk_d;
            bit_q    <= bit_d;
            sample_q <= sample_d;
            shift_q  <= shift_d;
            done_q   <= done_d;
        end
    end

    assign sclk         = sclk_q;
    assign sample_pulse = sample_q;
    assign shift_pulse  = shift_q;
    assign bit_cnt      = bit_q;
    assign byte_done    = done_q;

`ifdef SPI_BAUD_CFG_ERR_EN
    logic [5:0] cfg_q, cfg_d;
    logic       err_q, err_d;

    always_comb begin
        cfg_d = cfg_q;
        err_d = err_q;
        if (state_q == S_IDLE && run) begin
            cfg_d = {sppr, spr};
            err_d = 1'b0;
        end else if (state_q == S_RUN && {sppr, spr} != cfg_q) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cfg_q <= '0;
            err_q <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
            err_q <= err_d;
        end
    end

    assign cfg_err = err_q;
`else
    assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_baud_generator.sv
// Scoreboard bench for spi_baud_generator: a driver predicts each cycle
// from clock arithmetic, a negedge monitor compares the DUT against it.
module tb_spi_baud_generator;

    localparam int DIV_W = 12;
    localparam int BITS  = 8;

    logic             PCLK     = 1'b0;
    logic             PRESET   = 1'b1;
    logic [1:0]       spi_mode = 2'b00;
    logic             spiswai  = 1'b0;
    logic [2:0]       sppr     = 3'd0;
    logic [2:0]       spr      = 3'd0;
    logic             cpol     = 1'b0;
    logic             cpha     = 1'b0;
    logic             ss       = 1'b1;
    logic [DIV_W-1:0] BaudRateDivisor;
    logic             sclk;
    logic             sample_pulse;
    logic             shift_pulse;
    logic [2:0]       bit_cnt;
    logic             byte_done;
    logic             cfg_err;

    spi_baud_generator #(.DIV_W(DIV_W), .BITS(BITS)) dut (
        .PCLK            (PCLK),
        .PRESET          (PRESET),
        .spi_mode        (spi_mode),
        .spiswai         (spiswai),
        .sppr            (sppr),
        .spr             (spr),
        .cpol            (cpol),
        .cpha            (cpha),
        .ss              (ss),
        .BaudRateDivisor (BaudRateDivisor),
        .sclk            (sclk),
        .sample_pulse    (sample_pulse),
        .shift_pulse     (shift_pulse),
        .bit_cnt         (bit_cnt),
        .byte_done       (byte_done),
        .cfg_err         (cfg_err)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic       sclk;
        logic       sp;
        logic       sh;
        logic       bd;
        logic       ce;
        logic [2:0] bc;
    } exp_t;

    typedef struct {
        int due;
        int div;
    } div_t;

    exp_t rq[$];
    div_t dq[$];
    int   nchk  = 0;
    int   npass = 0;

    // Reference model: a run segment is described only by how many RUN
    // cycles have elapsed since entry and the half period latched then.
    bit       m_run = 1'b0;
    int       m_j   = 0;
    int       m_h   = 1;
    bit       m_cp  = 1'b0;
    bit       m_ch  = 1'b0;
    bit       m_err = 1'b0;
    bit [5:0] m_cfg = '0;

    function automatic bit runnable();
        return !ss && (spi_mode == 2'b00 ||
                       (spi_mode == 2'b01 && !spiswai));
    endfunction

    task automatic drive();
        exp_t e;
        div_t d;
        int   edges;
        int   n;
        bit   lead;
        bit   pulse;
        d.due = cyc;
        d.div = (int'(sppr) + 1) * (2 ** (int'(spr) + 1));
        dq.push_back(d);
        e.due  = cyc + 1;
        e.sclk = cpol;
        e.sp   = 1'b0;
        e.sh   = 1'b0;
        e.bd   = 1'b0;
        e.bc   = 3'd0;
        if (PRESET) begin
            m_run = 1'b0;
            m_err = 1'b0;
        end else begin
            if (m_run && {sppr, spr} != m_cfg) m_err = 1'b1;
            if (!m_run) begin
                if (runnable()) begin
                    m_run = 1'b1;
                    m_j   = 0;
                    m_h   = (int'(sppr) + 1) << spr;
                    m_cp  = cpol;
                    m_ch  = cpha;
                    m_err = 1'b0;
                    m_cfg = {sppr, spr};
                end
            end else if (!runnable()) begin
                m_run = 1'b0;
            end else begin
                m_j++;
            end
            if (m_run) begin
                edges  = m_j / m_h;
                e.sclk = m_cp ^ edges[0];
                e.bc   = 3'((edges / 2) % BITS);
                e.bd   = (m_j % m_h == 0) && edges > 0 &&
                         (edges % (2 * BITS) == 0);
                pulse  = ((m_j + 1) % m_h == 0);
                n      = (m_j + 1) / m_h;
                lead   = (n % 2 == 1);
                e.sp   = pulse && (lead != m_ch);
                e.sh   = pulse && (lead == m_ch);
            end
        end
`ifdef SPI_BAUD_CFG_ERR_EN
        e.ce = m_err;
`else
        e.ce = 1'b0;
`endif
        rq.push_back(e);
        @(posedge PCLK);
        #1;
    endtask

    task automatic run_n(input int n);
        repeat (n) drive();
    endtask

    exp_t me;
    div_t md;

    always @(negedge PCLK) begin
        while (dq.size() > 0 && dq[0].due <= cyc) begin
            md = dq.pop_front();
            nchk++;
            if (md.due == cyc && BaudRateDivisor == DIV_W'(md.div))
                npass++;
            else
                $display("FAIL div cyc=%0d got=%0d exp=%0d",
                         cyc, BaudRateDivisor, md.div);
        end
        while (rq.size() > 0 && rq[0].due <= cyc) begin
            me = rq.pop_front();
            nchk++;
            if (me.due == cyc && sclk === me.sclk &&
                sample_pulse === me.sp && shift_pulse === me.sh &&
                byte_done === me.bd && bit_cnt === me.bc &&
                cfg_err === me.ce)
                npass++;
            else
                $display({"FAIL outs cyc=%0d got sclk=%b smp=%b shf=%b",
                          " bd=%b bc=%0d ce=%b exp %b %b %b %b %0d %b"},
                         cyc, sclk, sample_pulse, shift_pulse, byte_done,
                         bit_cnt, cfg_err, me.sclk, me.sp, me.sh, me.bd,
                         me.bc, me.ce);
        end
    end

    int len;

    initial begin
        @(posedge PCLK);
        #1;
        PRESET = 1'b1;
        ss     = 1'b1;
        run_n(3);
        PRESET = 1'b0;

        sppr = 3'd0; spr = 3'd0; drive();
        sppr = 3'd1; spr = 3'd1; drive();
        sppr = 3'd7; spr = 3'd7; drive();

        sppr = 3'd1; spr = 3'd1; cpol = 1'b0; cpha = 1'b0;
        spi_mode = 2'b00;
        ss = 1'b0; run_n(70);
        ss = 1'b1; run_n(2);

        sppr = 3'd0; spr = 3'd0; cpol = 1'b1; cpha = 1'b1;
        run_n(1);
        ss = 1'b0; run_n(20);
        ss = 1'b1; run_n(2);

        sppr = 3'd1; spr = 3'd1; cpol = 1'b0; cpha = 1'b0;
        run_n(1);
        ss = 1'b0; run_n(30);
        spi_mode = 2'b01; spiswai = 1'b1; run_n(2);
        spiswai = 1'b0; run_n(10);
        spi_mode = 2'b00;
        ss = 1'b1; run_n(2);

        ss = 1'b0; run_n(20);
        spr = 3'd2; run_n(20);
        ss = 1'b1; run_n(2);
        ss = 1'b0; run_n(40);

        PRESET = 1'b1; run_n(1);
        PRESET = 1'b0; run_n(10);
        ss = 1'b1; run_n(2);

        for (int s = 0; s < 40; s++) begin
            ss       = 1'b1;
            spi_mode = 2'($urandom_range(0, 3));
            spiswai  = 1'($urandom_range(0, 1));
            cpol     = 1'($urandom_range(0, 1));
            cpha     = 1'($urandom_range(0, 1));
            sppr     = 3'($urandom_range(0, 3));
            spr      = 3'($urandom_range(0, 2));
            run_n($urandom_range(1, 4));
            ss       = 1'b0;
            spi_mode = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b00;
            spiswai  = 1'b0;
            len = $urandom_range(1, ((int'(sppr) + 1) << spr) * 4 * BITS + 4);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 99) < 2) begin
                    sppr = 3'($urandom_range(0, 3));
                    spr  = 3'($urandom_range(0, 2));
                end
                PRESET = ($urandom_range(0, 199) == 0);
                drive();
            end
            PRESET = 1'b0;
            case ($urandom_range(0, 2))
                0: ss = 1'b1;
                1: spi_mode = 2'($urandom_range(2, 3));
                default: begin
                    spi_mode = 2'b01;
                    spiswai  = 1'b1;
                end
            endcase
            drive();
        end

        ss = 1'b1; spi_mode = 2'b00; spiswai = 1'b0;
        run_n(2);
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        #1;
        nchk++;
        if (rq.size() == 0 && dq.size() == 0)
            npass++;
        else
            $display("FAIL drain got=%0d/%0d left exp=0/0",
                     rq.size(), dq.size());
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
